// File: rtl/bram_test_sequencer.sv
// bram_test_sequencer: writes a data pattern to every RAM word, reads it back and counts mismatches.
module bram_test_sequencer #(
  parameter int BITWIDTH_SYS = 16,
  parameter int BITWIDTH_IN  = 12,
  parameter int BITWIDTH_ADR = 6
) (
  input  logic                    CLK_SYS,
  input  logic                    RSTN,
  input  logic                    TRGG_START,
  input  logic                    ABORT,
  input  logic [1:0]              PATTERN_SEL,
  input  logic [BITWIDTH_SYS-1:0] SEED,
  output logic                    RAM_EN,
  output logic                    RAM_WE,
  output logic [BITWIDTH_ADR-1:0] RAM_ADR,
  output logic [BITWIDTH_SYS-1:0] RAM_DIN,
  input  logic [BITWIDTH_SYS-1:0] RAM_DOUT,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    PASS,
  output logic [BITWIDTH_ADR:0]   ERR_CNT,
  output logic [BITWIDTH_ADR-1:0] FIRST_ERR_ADR
);
  localparam logic [2:0] IDLE = 3'd0, WRITE = 3'd1, READ = 3'd2, DRAIN = 3'd3, FINISH = 3'd4;
  localparam int SH = BITWIDTH_SYS - BITWIDTH_IN;
  logic [2:0]              state;
  logic [BITWIDTH_ADR-1:0] cnt, cmp_adr, first_err;
  logic                    cmp_valid;
  logic [1:0]              sel;
  logic [BITWIDTH_SYS-1:0] seed, exp_word;
  logic [BITWIDTH_ADR:0]   err_cnt;
  logic                    busy, start, mismatch;
  function automatic logic [BITWIDTH_SYS-1:0] pattern(input logic [BITWIDTH_ADR-1:0] adr,
                                                      input logic [1:0] ps,
                                                      input logic [BITWIDTH_SYS-1:0] sd);
    logic [BITWIDTH_SYS-1:0] p0;
    p0 = BITWIDTH_SYS'(adr) << SH;
    return ps == 2'd0 ? p0 : ps == 2'd1 ? ~p0 : ps == 2'd2 ? sd : sd ^ p0;
  endfunction
  assign busy     = state == WRITE || state == READ || state == DRAIN;
  assign start    = TRGG_START && !ABORT && (state == IDLE || state == FINISH);
  assign exp_word = pattern(cmp_adr, sel, seed);
  // only the upper BITWIDTH_IN bits carry RAM data; the rest are don't-care
  assign mismatch = cmp_valid && (((RAM_DOUT ^ exp_word) >> SH) != '0);
  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      cmp_valid <= 1'b0;
      cmp_adr   <= '0;
      sel       <= '0;
      seed      <= '0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      cmp_valid <= state == READ;
      cmp_adr   <= cnt;
      if (busy && ABORT) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (start) begin
        state <= WRITE;
        cnt   <= '0;
        sel   <= PATTERN_SEL;
        seed  <= SEED;
      end else if (state == WRITE || state == READ) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) state <= state == WRITE ? READ : DRAIN;
      end else if (state == DRAIN) begin
        state <= FINISH;
      end
      if (start) begin
        err_cnt   <= '0;
        first_err <= '0;
      end else if (mismatch) begin
        err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) first_err <= cmp_adr;
      end
    end
  end
  assign RAM_EN        = state == WRITE || state == READ;
  assign RAM_WE        = state == WRITE;
  assign RAM_ADR       = RAM_EN ? cnt : '0;
  assign RAM_DIN       = RAM_WE ? pattern(cnt, sel, seed) : '0;
  assign BUSY          = busy;
  assign DONE          = state == FINISH;
  assign PASS          = DONE && err_cnt == '0;
  assign ERR_CNT       = err_cnt;
  assign FIRST_ERR_ADR = first_err;
endmodule
